// File: rtl/flag_cond_unit.sv
// Flag register plus condition evaluator with a valid/ready handshake.
// Optional 4-deep flag save/restore stack is built when FLAG_COND_STACK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a condition request, cond_ready high
// EVAL  | evaluating latched cond against flags_q
// DONE  | result held on res_true/res_valid until res_ready
module flag_cond_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   input  logic       C,
   input  logic       flag_we,
   input  logic [3:0] cond,
   input  logic       cond_valid,
   output logic       cond_ready,
   output logic       res_valid,
   output logic       res_true,
   input  logic       res_ready,
   input  logic       save,
   input  logic       restore,
   output logic       stack_full,
   output logic       stack_empty,
   output logic       err,
   output logic [3:0] flags_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cond_q;

   function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
      logic fn, fz, fc, fv;
      logic r;
      fn = f[3];
      fz = f[2];
      fc = f[1];
      fv = f[0];
      case (cc)
         4'd0:    r = fz;
         4'd1:    r = !fz;
         4'd2:    r = fc;
         4'd3:    r = !fc;
         4'd4:    r = fn;
         4'd5:    r = !fn;
         4'd6:    r = fv;
         4'd7:    r = !fv;
         4'd8:    r = fc & !fz;
         4'd9:    r = !fc | fz;
         4'd10:   r = (fn == fv);
         4'd11:   r = (fn != fv);
         4'd12:   r = !fz & (fn == fv);
         4'd13:   r = fz | (fn != fv);
         4'd14:   r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cond_ready = 1'b0;
      res_valid  = 1'b0;
      case (state)
         IDLE: begin
            cond_ready = 1'b1;
            if (cond_valid) state_nxt = EVAL;
         end
         EVAL: state_nxt = DONE;
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             cond_q <= 4'd0;
      else if (state == IDLE && cond_valid)   cond_q <= cond;
   end

   // flags_q already reflects any write made at the accepting edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              res_true <= 1'b0;
      else if (state == EVAL)  res_true <= cond_eval(cond_q, flags_q);
   end

`ifdef FLAG_COND_STACK_EN
   logic [3:0] stack_mem [4];
   logic [2:0] depth;
   logic [1:0] top_idx;
   logic       do_save, do_restore;
   logic       push_ok, push_fail, pop_ok, pop_fail;

   // simultaneous save and restore cancel each other out
   assign do_save    = save & ~restore;
   assign do_restore = restore & ~save;
   assign push_ok    = do_save & (depth != 3'd4);
   assign push_fail  = do_save & (depth == 3'd4);
   assign pop_ok     = do_restore & (depth != 3'd0);
   assign pop_fail   = do_restore & (depth == 3'd0);
   assign top_idx    = depth[1:0] - 2'd1;

   assign stack_full  = (depth == 3'd4);
   assign stack_empty = (depth == 3'd0);

   always_ff @(posedge clk) begin
      if (push_ok) stack_mem[depth[1:0]] <= flags_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'd0;
         depth   <= 3'd0;
         err     <= 1'b0;
      end else begin
         if (pop_ok)       flags_q <= stack_mem[top_idx];
         else if (flag_we) flags_q <= {N, Z, C, V};
         if (push_ok)      depth <= depth + 3'd1;
         else if (pop_ok)  depth <= depth - 3'd1;
         if (push_fail | pop_fail) err <= 1'b1;
      end
   end
`else
   logic unused_stack_ops;
   assign unused_stack_ops = save | restore;

   assign stack_full  = 1'b0;
   assign stack_empty = 1'b1;
   assign err         = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       flags_q <= 4'd0;
      else if (flag_we) flags_q <= {N, Z, C, V};
   end
`endif

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: condition decode table plus handshake,
// hold, reset and (when FLAG_COND_STACK_EN is defined) flag stack sequences.
module tb_flag_cond_unit;

   logic       clk;
   logic       rst_n;
   logic       z, n, v, c;
   logic       flag_we;
   logic [3:0] cond;
   logic       cond_valid;
   logic       cond_ready;
   logic       res_valid;
   logic       res_true;
   logic       res_ready;
   logic       save;
   logic       restore;
   logic       stack_full;
   logic       stack_empty;
   logic       err;
   logic [3:0] flags_q;

   int errors = 0;
   int checks = 0;

   flag_cond_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Z           (z),
      .N           (n),
      .V           (v),
      .C           (c),
      .flag_we     (flag_we),
      .cond        (cond),
      .cond_valid  (cond_valid),
      .cond_ready  (cond_ready),
      .res_valid   (res_valid),
      .res_true    (res_true),
      .res_ready   (res_ready),
      .save        (save),
      .restore     (restore),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .err         (err),
      .flags_q     (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] flags;   // {N,Z,C,V}
      logic [3:0] cc;
      logic       exp;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_flags(input logic [3:0] f);
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
   endtask

   task automatic write_flags(input logic [3:0] f);
      drive_flags(f);
      flag_we = 1'b1;
      step();
      flag_we = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flag_we = 1'b0; cond_valid = 1'b0; res_ready = 1'b0;
      save = 1'b0; restore = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      drive_flags(4'b0000);
      flag_we = 1'b0; cond = 4'd0; cond_valid = 1'b0; res_ready = 1'b0;
      save = 1'b0; restore = 1'b0;

      vecs[0]  = '{4'b0110, 4'd8,  1'b0};
      vecs[1]  = '{4'b0110, 4'd2,  1'b1};
      vecs[2]  = '{4'b1000, 4'd11, 1'b1};
      vecs[3]  = '{4'b1000, 4'd10, 1'b0};
      vecs[4]  = '{4'b1000, 4'd13, 1'b1};
      vecs[5]  = '{4'b1000, 4'd14, 1'b1};
      vecs[6]  = '{4'b1000, 4'd15, 1'b0};
      vecs[7]  = '{4'b0110, 4'd0,  1'b1};
      vecs[8]  = '{4'b0000, 4'd1,  1'b1};
      vecs[9]  = '{4'b0000, 4'd3,  1'b1};
      vecs[10] = '{4'b1000, 4'd4,  1'b1};
      vecs[11] = '{4'b0000, 4'd5,  1'b1};
      vecs[12] = '{4'b0001, 4'd6,  1'b1};
      vecs[13] = '{4'b0001, 4'd7,  1'b0};
      vecs[14] = '{4'b0010, 4'd8,  1'b1};
      vecs[15] = '{4'b0010, 4'd9,  1'b0};
      vecs[16] = '{4'b1001, 4'd12, 1'b1};
      vecs[17] = '{4'b0100, 4'd12, 1'b0};
      vecs[18] = '{4'b1001, 4'd13, 1'b0};
      vecs[19] = '{4'b1111, 4'd15, 1'b0};

      #2;
      chk("rst_flags", flags_q, 4'd0);
      chk("rst_res_valid", {3'b0, res_valid}, 4'd0);
      chk("rst_res_true", {3'b0, res_true}, 4'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("rel_cond_ready", {3'b0, cond_ready}, 4'd1);
      chk("rel_stack_empty", {3'b0, stack_empty}, 4'd1);
      chk("rel_stack_full", {3'b0, stack_full}, 4'd0);
      chk("rel_err", {3'b0, err}, 4'd0);

      // flags written at the accepting edge are the ones evaluated
      for (int i = 0; i < 20; i++) begin
         drive_flags(vecs[i].flags);
         flag_we = 1'b1;
         cond = vecs[i].cc;
         cond_valid = 1'b1;
         step();
         flag_we = 1'b0;
         cond_valid = 1'b0;
         cond = ~vecs[i].cc;
         chk($sformatf("v%0d_flags", i), flags_q, vecs[i].flags);
         chk($sformatf("v%0d_valid_early", i), {3'b0, res_valid}, 4'd0);
         chk($sformatf("v%0d_ready_busy", i), {3'b0, cond_ready}, 4'd0);
         step();
         chk($sformatf("v%0d_valid", i), {3'b0, res_valid}, 4'd1);
         chk($sformatf("v%0d_res", i), {3'b0, res_true}, {3'b0, vecs[i].exp});
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         chk($sformatf("v%0d_back_idle", i), {3'b0, cond_ready}, 4'd1);
         chk($sformatf("v%0d_valid_drop", i), {3'b0, res_valid}, 4'd0);
      end

      // result held in DONE while flags keep changing
      write_flags(4'b0100);
      cond = 4'd0;
      cond_valid = 1'b1;
      step();
      cond_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         drive_flags(4'(i * 3 + 1) & 4'b1011);
         flag_we = 1'b1;
         step();
         chk($sformatf("hold%0d_flags", i), flags_q, 4'(i * 3 + 1) & 4'b1011);
         chk($sformatf("hold%0d_valid", i), {3'b0, res_valid}, 4'd1);
         chk($sformatf("hold%0d_res", i), {3'b0, res_true}, 4'd1);
         chk($sformatf("hold%0d_cready", i), {3'b0, cond_ready}, 4'd0);
      end
      flag_we = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("hold_release_idle", {3'b0, cond_ready}, 4'd1);
      chk("hold_release_valid", {3'b0, res_valid}, 4'd0);

      // asynchronous reset while in EVAL
      write_flags(4'b1111);
      cond = 4'd14;
      cond_valid = 1'b1;
      step();
      cond_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_flags", flags_q, 4'd0);
      chk("arst_valid", {3'b0, res_valid}, 4'd0);
      chk("arst_idle", {3'b0, cond_ready}, 4'd1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("arst_no_resp%0d", i), {2'b0, res_valid, cond_ready}, 4'b0001);
      end

`ifdef FLAG_COND_STACK_EN
      do_reset();
      for (int i = 0; i < 4; i++) begin
         write_flags(4'(i + 3));
         save = 1'b1;
         step();
         save = 1'b0;
      end
      chk("stk_full", {2'b0, stack_full, stack_empty}, 4'b0010);
      chk("stk_err_before", {3'b0, err}, 4'd0);
      save = 1'b1;
      step();
      save = 1'b0;
      chk("stk_overflow_err", {3'b0, err}, 4'd1);
      chk("stk_still_full", {3'b0, stack_full}, 4'd1);
      for (int i = 3; i >= 0; i--) begin
         restore = 1'b1;
         step();
         restore = 1'b0;
         chk($sformatf("stk_pop%0d", i), flags_q, 4'(i + 3));
      end
      chk("stk_empty", {2'b0, stack_full, stack_empty}, 4'b0001);
      restore = 1'b1;
      step();
      restore = 1'b0;
      chk("stk_underflow_flags", flags_q, 4'd3);
      chk("stk_underflow_empty", {3'b0, stack_empty}, 4'd1);

      do_reset();
      restore = 1'b1;
      drive_flags(4'b1010);
      flag_we = 1'b1;
      step();
      restore = 1'b0;
      flag_we = 1'b0;
      chk("failpop_we_wins", flags_q, 4'b1010);
      chk("failpop_err", {3'b0, err}, 4'd1);

      do_reset();
      write_flags(4'b0101);
      // push takes the value before the same-cycle write
      drive_flags(4'b1100);
      flag_we = 1'b1;
      save = 1'b1;
      step();
      save = 1'b0;
      flag_we = 1'b0;
      chk("save_we_flags", flags_q, 4'b1100);
      chk("save_depth1", {2'b0, stack_full, stack_empty}, 4'b0000);
      save = 1'b1;
      restore = 1'b1;
      step();
      save = 1'b0;
      restore = 1'b0;
      chk("both_nochange", {1'b0, err, stack_full, stack_empty}, 4'b0000);
      chk("both_flags", flags_q, 4'b1100);
      drive_flags(4'b1111);
      flag_we = 1'b1;
      restore = 1'b1;
      step();
      flag_we = 1'b0;
      restore = 1'b0;
      chk("pop_beats_we", flags_q, 4'b0101);
      chk("pop_beats_we_empty", {1'b0, err, stack_full, stack_empty}, 4'b0001);
`else
      do_reset();
      write_flags(4'b0110);
      save = 1'b1;
      step();
      save = 1'b0;
      restore = 1'b1;
      step();
      restore = 1'b0;
      chk("nostk_flags", flags_q, 4'b0110);
      chk("nostk_status", {1'b0, err, stack_full, stack_empty}, 4'b0001);
      drive_flags(4'b1001);
      flag_we = 1'b1;
      restore = 1'b1;
      step();
      flag_we = 1'b0;
      restore = 1'b0;
      chk("nostk_we", flags_q, 4'b1001);
      chk("nostk_err", {3'b0, err}, 4'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
